// File: rtl/bsg_manycore_reg_id_alloc.sv
// bsg_manycore_reg_id_alloc
//   Allocator for a pool of reg_id tags. It tracks one pending bit per id,
//   offers the lowest free id, takes ids back on response, and can drain
//   (fence) until nothing is outstanding.
//
// Ports
//   clk_i        : clock
//   reset_n_i    : asynchronous active-low reset
//   id_v_o       : a free id is offered (never while draining)
//   id_o         : offered id, lowest non-pending index (0 when none free)
//   id_yumi_i    : consumer takes id_o this cycle
//   free_v_i     : a reg_id is being returned
//   free_id_i    : the returned reg_id
//   fence_v_i    : request to drain all outstanding ids
//   fence_done_o : one-cycle pulse when a drain completes
//   count_o      : number of outstanding ids
//   empty_o      : count_o == 0
//   error_o      : sticky protocol-violation flag

package bsg_manycore_pkg;
   localparam int bsg_manycore_reg_id_width_gp = 5;
endpackage

module bsg_manycore_reg_id_alloc
   import bsg_manycore_pkg::*;
#(
   parameter int  reg_id_width_p = bsg_manycore_reg_id_width_gp,
   parameter int  num_ids_p      = 2**reg_id_width_p,
   localparam int count_width_lp = $clog2(num_ids_p+1)
)(
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   output logic                      id_v_o,
   output logic [reg_id_width_p-1:0] id_o,
   input  logic                      id_yumi_i,
   input  logic                      free_v_i,
   input  logic [reg_id_width_p-1:0] free_id_i,
   input  logic                      fence_v_i,
   output logic                      fence_done_o,
   output logic [count_width_lp-1:0] count_o,
   output logic                      empty_o,
   output logic                      error_o
);

   typedef enum logic {IDLE, DRAIN} state_e;

   state_e                    state, state_next;
   logic [num_ids_p-1:0]      pending, pending_next;
   logic [count_width_lp-1:0] count, count_next;
   logic                      error;

   logic                      any_free;
   logic [reg_id_width_p-1:0] free_idx;
   logic                      alloc;
   logic                      free_ok;
   logic                      violation;

   // Priority pick of the lowest free id from registered state only, so a
   // just-freed id is not visible until the cycle after its free edge.
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < num_ids_p; i++) begin
         if (!pending[i] && !any_free) begin
            any_free = 1'b1;
            free_idx = reg_id_width_p'(i);
         end
      end
   end

   assign id_v_o = (state == IDLE) && any_free;
   assign id_o   = free_idx;
   assign alloc  = id_yumi_i && id_v_o;

   // An out-of-range free_id_i matches no index and so falls into the
   // violation path without a separate range compare.
   always_comb begin
      free_ok = 1'b0;
      for (int unsigned i = 0; i < num_ids_p; i++) begin
         if (free_v_i && (free_id_i == reg_id_width_p'(i)) && pending[i])
            free_ok = 1'b1;
      end
   end

   assign violation = (id_yumi_i && !id_v_o) || (free_v_i && !free_ok);

   // The allocated id is always non-pending and the freed id always pending,
   // so the set and clear never target the same bit.
   always_comb begin
      pending_next = pending;
      for (int unsigned i = 0; i < num_ids_p; i++) begin
         if (alloc && (free_idx == reg_id_width_p'(i)))
            pending_next[i] = 1'b1;
         if (free_ok && (free_id_i == reg_id_width_p'(i)))
            pending_next[i] = 1'b0;
      end
      count_next = count + count_width_lp'(alloc) - count_width_lp'(free_ok);
   end

   always_comb begin
      state_next   = state;
      fence_done_o = 1'b0;
      case (state)
         IDLE: begin
            if (fence_v_i)
               state_next = DRAIN;
         end
         DRAIN: begin
            if (count == '0) begin
               fence_done_o = 1'b1;
               state_next   = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state   <= IDLE;
         pending <= '0;
         count   <= '0;
         error   <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         count   <= count_next;
         if (violation)
            error <= 1'b1;
      end
   end

   assign count_o = count;
   assign empty_o = (count == '0);
   assign error_o = error;

endmodule

// File: tb/tb_bsg_manycore_reg_id_alloc.sv
module tb_bsg_manycore_reg_id_alloc;
   localparam int W  = 5;
   localparam int N  = 32;
   localparam int CW = $clog2(N+1);

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic          id_v_o;
   logic [W-1:0]  id_o;
   logic          id_yumi_i;
   logic          free_v_i;
   logic [W-1:0]  free_id_i;
   logic          fence_v_i;
   logic          fence_done_o;
   logic [CW-1:0] count_o;
   logic          empty_o;
   logic          error_o;

   int total = 0;
   int bad   = 0;

   // Reference model: a set of outstanding ids, a draining flag, a sticky error.
   bit m_pend[N];
   bit m_drain;
   bit m_err;

   always #5 clk = ~clk;

   bsg_manycore_reg_id_alloc #(.reg_id_width_p(W), .num_ids_p(N)) dut (
      .clk_i(clk), .reset_n_i(reset_n_i),
      .id_v_o(id_v_o), .id_o(id_o), .id_yumi_i(id_yumi_i),
      .free_v_i(free_v_i), .free_id_i(free_id_i),
      .fence_v_i(fence_v_i), .fence_done_o(fence_done_o),
      .count_o(count_o), .empty_o(empty_o), .error_o(error_o)
   );

   function automatic int m_lowest();
      for (int i = 0; i < N; i++)
         if (!m_pend[i]) return i;
      return -1;
   endfunction

   function automatic int m_count();
      int c;
      c = 0;
      for (int i = 0; i < N; i++)
         if (m_pend[i]) c++;
      return c;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_drain = 1'b0;
      m_err   = 1'b0;
   endfunction

   function automatic void m_step(bit y, bit fv, int fid, bit fe);
      int lo;
      bit offer;
      bit take;
      bit give;
      bit done;
      lo    = m_lowest();
      offer = !m_drain && (lo >= 0);
      take  = y && offer;
      give  = fv && (fid < N) && m_pend[fid];
      done  = m_drain && (m_count() == 0);
      if ((y && !offer) || (fv && !give)) m_err = 1'b1;
      if (!m_drain) begin
         if (fe) m_drain = 1'b1;
      end else if (done) begin
         m_drain = 1'b0;
      end
      if (take) m_pend[lo] = 1'b1;
      if (give) m_pend[fid] = 1'b0;
   endfunction

   task automatic chk(string tag, string field, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   task automatic check_outputs(string tag);
      int lo;
      int c;
      lo = m_lowest();
      c  = m_count();
      chk(tag, "id_v",  32'(id_v_o),       32'(!m_drain && (lo >= 0)));
      chk(tag, "id",    32'(id_o),         (lo < 0) ? 0 : lo);
      chk(tag, "count", 32'(count_o),      c);
      chk(tag, "empty", 32'(empty_o),      32'(c == 0));
      chk(tag, "done",  32'(fence_done_o), 32'(m_drain && (c == 0)));
      chk(tag, "error", 32'(error_o),      32'(m_err));
   endtask

   // Drive one cycle of inputs, check current outputs, advance model and clock.
   task automatic apply(string tag, bit y, bit fv, int fid, bit fe);
      id_yumi_i = y;
      free_v_i  = fv;
      free_id_i = W'(fid);
      fence_v_i = fe;
      #1;
      check_outputs(tag);
      m_step(y, fv, fid, fe);
      @(posedge clk);
      #1;
   endtask

   // Reset is asserted between edges and checked before any clock edge.
   task automatic do_reset(string tag);
      id_yumi_i = 1'b0;
      free_v_i  = 1'b0;
      free_id_i = '0;
      fence_v_i = 1'b0;
      reset_n_i = 1'b0;
      #1;
      m_reset();
      check_outputs(tag);
      @(posedge clk);
      #1;
      reset_n_i = 1'b1;
   endtask

   initial begin
      int q[$];
      int fid;
      reset_n_i = 1'b0;
      #1;
      do_reset("por");

      // Fill the whole pool in order.
      for (int i = 0; i < N; i++) apply("fill", 1'b1, 1'b0, 0, 1'b0);
      chk("fill", "count_full", 32'(count_o), 32);
      chk("fill", "id_v_full",  32'(id_v_o),  0);
      apply("fill_over", 1'b1, 1'b0, 0, 1'b0);
      chk("fill_over", "error_yumi", 32'(error_o), 1);
      chk("fill_over", "count_kept", 32'(count_o), 32);
      do_reset("rst1");

      // Free id 1 after allocating 0..3: not offered until after the free edge.
      for (int i = 0; i < 4; i++) apply("alloc4", 1'b1, 1'b0, 0, 1'b0);
      apply("free1", 1'b0, 1'b1, 1, 1'b0);
      chk("free1", "id_after", 32'(id_o),    1);
      chk("free1", "count3",   32'(count_o), 3);
      do_reset("rst2");

      // Simultaneous allocate of 5 and free of 2.
      for (int i = 0; i < 5; i++) apply("alloc5", 1'b1, 1'b0, 0, 1'b0);
      apply("swap", 1'b1, 1'b1, 2, 1'b0);
      chk("swap", "count5", 32'(count_o), 5);
      chk("swap", "id2",    32'(id_o),    2);

      // Free of a non-pending id.
      apply("bad_free", 1'b0, 1'b1, 7, 1'b0);
      chk("bad_free", "error",  32'(error_o), 1);
      chk("bad_free", "count5", 32'(count_o), 5);
      for (int i = 0; i < 3; i++) apply("err_hold", 1'b0, 1'b0, 0, 1'b0);
      do_reset("rst3");

      // Fence with three outstanding.
      for (int i = 0; i < 3; i++) apply("alloc3", 1'b1, 1'b0, 0, 1'b0);
      apply("fence3", 1'b0, 1'b0, 0, 1'b1);
      chk("fence3", "id_v_drain", 32'(id_v_o), 0);
      for (int i = 0; i < 3; i++) apply("drain_free", 1'b0, 1'b1, i, 1'b0);
      chk("drain_free", "done_pulse", 32'(fence_done_o), 1);
      chk("drain_free", "count0",     32'(count_o),      0);
      apply("drain_end", 1'b0, 1'b0, 0, 1'b0);
      chk("drain_end", "done_low", 32'(fence_done_o), 0);
      chk("drain_end", "id_v_back", 32'(id_v_o),      1);
      do_reset("rst4");

      // Fence with nothing outstanding, then a repeated fence while draining.
      apply("fence0", 1'b0, 1'b0, 0, 1'b1);
      chk("fence0", "done_next", 32'(fence_done_o), 1);
      apply("fence0_end", 1'b0, 1'b0, 0, 1'b0);
      chk("fence0_end", "done_once", 32'(fence_done_o), 0);
      apply("fence_alloc", 1'b1, 1'b0, 0, 1'b1);
      chk("fence_alloc", "count1", 32'(count_o), 1);
      apply("fence_again", 1'b0, 1'b0, 0, 1'b1);
      apply("fence_free",  1'b0, 1'b1, 0, 1'b1);
      apply("fence_fin",   1'b0, 1'b0, 0, 1'b0);
      apply("fence_post",  1'b0, 1'b0, 0, 1'b0);

      // Reset in the middle of a drain.
      apply("md_a", 1'b1, 1'b0, 0, 1'b0);
      apply("md_b", 1'b1, 1'b0, 0, 1'b0);
      apply("md_fence", 1'b0, 1'b0, 0, 1'b1);
      do_reset("mid_drain_reset");
      for (int i = 0; i < 3; i++) apply("post_reset", 1'b0, 1'b0, 0, 1'b0);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset("rnd_reset");
         end else begin
            q.delete();
            for (int i = 0; i < N; i++) if (m_pend[i]) q.push_back(i);
            if ((q.size() > 0) && ($urandom_range(0, 9) != 0))
               fid = q[$urandom_range(0, q.size() - 1)];
            else
               fid = int'($urandom_range(0, N - 1));
            apply("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fid,
                  ($urandom_range(0, 19) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bsg_manycore_reg_id_alloc.md
BSG_MANYCORE_REG_ID_ALLOC -- requirements
Module: bsg_manycore_reg_id_alloc

Interface
REQ-001 The module SHALL have parameter reg_id_width_p, default bsg_manycore_reg_id_width_gp, giving the width of a reg_id tag.
REQ-002 The module SHALL have parameter num_ids_p, default 2**reg_id_width_p, giving the pool size; legal range is 1..2**reg_id_width_p.
REQ-003 The module SHALL have local parameter count_width_lp = clog2(num_ids_p+1).
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The module SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port id_v_o, output, 1 bit: a free reg_id is offered.
REQ-007 The module SHALL have port id_o, output, reg_id_width_p bits: the offered reg_id.
REQ-008 The module SHALL have port id_yumi_i, input, 1 bit: the consumer takes id_o this cycle.
REQ-009 The module SHALL have port free_v_i, input, 1 bit: a response returns a reg_id.
REQ-010 The module SHALL have port free_id_i, input, reg_id_width_p bits: the reg_id being returned.
REQ-011 The module SHALL have port fence_v_i, input, 1 bit: request to drain all outstanding ids.
REQ-012 The module SHALL have port fence_done_o, output, 1 bit: one-cycle pulse when the drain completes.
REQ-013 The module SHALL have port count_o, output, count_width_lp bits: number of outstanding ids.
REQ-014 The module SHALL have port empty_o, output, 1 bit: count_o == 0.
REQ-015 The module SHALL have port error_o, output, 1 bit: sticky protocol-violation flag.

Function
REQ-016 The module SHALL keep a pending bit per id in 0..num_ids_p-1.
REQ-017 The module SHALL drive id_o as the lowest-index non-pending id, decoded combinationally from registered state only; id_o SHALL be 0 when none is free.
REQ-018 In state IDLE, id_v_o SHALL be 1 exactly when at least one id is non-pending; in state DRAIN it SHALL be 0.
REQ-019 On id_yumi_i & id_v_o, the pending bit of id_o SHALL be set at the next edge and count_o SHALL increment.
REQ-020 On free_v_i with free_id_i pending, that bit SHALL clear at the next edge and count_o SHALL decrement.
REQ-021 A freed id SHALL NOT be offered in the same cycle it is freed; it becomes eligible the following cycle (no bypass).
REQ-022 On a simultaneous valid allocate of id X and free of id Y (X != Y), both SHALL take effect and count_o SHALL be unchanged.
REQ-023 A free of a non-pending id, a free_id_i >= num_ids_p, or id_yumi_i while id_v_o=0 SHALL set error_o (sticky until reset) and SHALL NOT change pending bits or count_o.
REQ-024 The FSM SHALL have states IDLE and DRAIN.
REQ-025 In IDLE, fence_v_i SHALL transition the FSM to DRAIN; an allocate in that same cycle is still honoured.
REQ-026 In DRAIN, while empty_o=0 the FSM SHALL stay in DRAIN, and frees SHALL be processed normally.
REQ-027 In DRAIN, when empty_o=1 (registered count), fence_done_o SHALL pulse high for exactly one cycle and the FSM SHALL return to IDLE at the same edge.
REQ-028 fence_v_i asserted while already in DRAIN SHALL be ignored (no extra pulse).
REQ-029 A fence issued with count 0 SHALL produce fence_done_o on the cycle after entry to DRAIN.
REQ-030 count_o SHALL never exceed num_ids_p nor underflow below 0.

Reset
REQ-031 reset_n_i=0 SHALL immediately (asynchronously) clear all pending bits, set count_o=0 and error_o=0, and put the FSM in IDLE, giving id_v_o=1, id_o=0, empty_o=1 and fence_done_o=0.
REQ-032 Reset asserted mid-drain or with ids outstanding SHALL discard all state; no fence_done_o pulse SHALL follow.

Verification
REQ-033 Scenario: reset, then id_yumi_i held 32 cycles (width 5) -> id_o = 0,1,...,31; count_o=32; id_v_o=0 on cycle 33.
REQ-034 Scenario: allocate 0..3, free id 1 -> id_o=1 on the cycle after the free edge, not before; count_o 4 -> 3.
REQ-035 Scenario: count=5, allocate id 5 and free id 2 in the same cycle -> count_o stays 5, and the next id_o is 2.
REQ-036 Scenario: 3 outstanding, pulse fence_v_i -> id_v_o=0; free all three -> fence_done_o single pulse the cycle after count_o reaches 0; id_v_o=1 after that.
REQ-037 Scenario: free of non-pending id 7 -> error_o=1 persisting, count_o unchanged; reset_n_i low mid-drain -> all outputs at reset values, no fence_done_o.
REQ-038 Scenario: fence_v_i with count 0 -> fence_done_o on the next cycle only; a second fence_v_i during DRAIN produces no extra pulse.
